// File: rtl/march_host_seq_if.sv
// Pin bundle between the March C- host sequencer and the memory-controller pins,
// plus the host-side control/status handshake.
interface march_host_seq_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] idata;
  logic              ce;
  logic              csb;
  logic              web;
  logic              oeb;
  logic [DATA_W-1:0] odata;
  logic              busy;
  logic              done;
  logic              pass;
  logic              fail_valid;
  logic [ADDR_W-1:0] fail_addr;
  logic [2:0]        fail_elem;
  logic [CNT_W-1:0]  fail_cnt;

  modport master (
    input  start, abort, odata,
    output addr, idata, ce, csb, web, oeb,
    output busy, done, pass, fail_valid, fail_addr, fail_elem, fail_cnt
  );

  modport slave (
    output start, abort, odata,
    input  addr, idata, ce, csb, web, oeb,
    input  busy, done, pass, fail_valid, fail_addr, fail_elem, fail_cnt
  );
endinterface

// File: rtl/march_host_seq.sv
// March C- initiator driving the memory-controller pins from outside the controller;
// logs each read mismatch (address, element, saturating count) for the repair flow.
module march_host_seq #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int ADDR_MAX = 65535,
  parameter int SETUP_C  = 1,
  parameter int CE_C     = 2,
  parameter int RD_LAT   = 3,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  march_host_seq_if.master    hif
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RDWAIT, NEXT} state_t;

  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(ADDR_MAX);
  localparam int CMAX  = (SETUP_C > CE_C) ? ((SETUP_C > RD_LAT) ? SETUP_C : RD_LAT)
                                          : ((CE_C > RD_LAT) ? CE_C : RD_LAT);
  localparam int CYC_W = $clog2(CMAX + 1);

  state_t            state, state_nx;
  logic [CYC_W-1:0]  cyc;
  logic [2:0]        elem;
  logic              op;
  logic [ADDR_W-1:0] addr;
  logic              busy, done, pass, fail_valid;
  logic [ADDR_W-1:0] fail_addr;
  logic [2:0]        fail_elem;
  logic [CNT_W-1:0]  fail_cnt;

  logic              is_wr, down, last_op, at_end, run_end, in_acc, cmp, mism, go;
  logic [DATA_W-1:0] exp_rd, wr_data;

  // E0 is write-only and E5 read-only; E1..E4 read (op 0) then write (op 1).
  assign is_wr   = (elem == 3'd0) || op;
  assign last_op = (elem == 3'd0) || (elem == 3'd5) || op;
  assign down    = (elem == 3'd3) || (elem == 3'd4);
  assign exp_rd  = ((elem == 3'd2) || (elem == 3'd4)) ? '1 : '0;
  assign wr_data = ((elem == 3'd1) || (elem == 3'd3)) ? '1 : '0;
  assign at_end  = down ? (addr == '0) : (addr == A_LAST);
  assign run_end = last_op && at_end && (elem == 3'd5);
  assign go      = hif.start && !hif.abort;
  assign cmp     = (state == RDWAIT) && (cyc == CYC_W'(RD_LAT - 1)) && !hif.abort;
  assign mism    = cmp && (hif.odata != exp_rd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (go) state_nx = SETUP;
      SETUP:   if (cyc == CYC_W'(SETUP_C - 1)) state_nx = STROBE;
      STROBE:  if (cyc == CYC_W'(CE_C - 1)) state_nx = HOLD;
      HOLD:    state_nx = is_wr ? NEXT : RDWAIT;
      RDWAIT:  if (cyc == CYC_W'(RD_LAT - 1)) state_nx = NEXT;
      NEXT:    state_nx = run_end ? IDLE : SETUP;
      default: state_nx = IDLE;
    endcase
    if (hif.abort && (state != IDLE)) state_nx = IDLE;
  end

  // Pins decode straight from registered state so abort/reset release them at once.
  assign in_acc    = (state == SETUP) || (state == STROBE) || (state == HOLD) || (state == RDWAIT);
  assign hif.addr  = addr;
  assign hif.idata = (in_acc && is_wr) ? wr_data : '0;
  assign hif.ce    = (state == STROBE);
  assign hif.csb   = !in_acc;
  assign hif.web   = !(in_acc && is_wr);
  assign hif.oeb   = !(in_acc && !is_wr);

  assign hif.busy       = busy;
  assign hif.done       = done;
  assign hif.pass       = pass;
  assign hif.fail_valid = fail_valid;
  assign hif.fail_addr  = fail_addr;
  assign hif.fail_elem  = fail_elem;
  assign hif.fail_cnt   = fail_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc <= '0;
    else     cyc <= (state_nx != state) ? '0 : cyc + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elem       <= '0;
      op         <= 1'b0;
      addr       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_valid <= 1'b0;
      fail_addr  <= '0;
      fail_elem  <= '0;
      fail_cnt   <= '0;
    end else begin
      fail_valid <= 1'b0;
      if (state == IDLE) begin
        if (go) begin
          busy      <= 1'b1;
          done      <= 1'b0;
          pass      <= 1'b0;
          fail_addr <= '0;
          fail_elem <= '0;
          fail_cnt  <= '0;
          elem      <= '0;
          op        <= 1'b0;
          addr      <= '0;
        end
      end else if (hif.abort) begin
        busy <= 1'b0;
      end else begin
        if (mism) begin
          fail_valid <= 1'b1;
          fail_addr  <= addr;
          fail_elem  <= elem;
          if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
        end
        if (state == NEXT) begin
          if (!last_op) begin
            op <= 1'b1;
          end else begin
            op <= 1'b0;
            if (!at_end) begin
              addr <= down ? addr - 1'b1 : addr + 1'b1;
            end else if (elem != 3'd5) begin
              // Down elements E3/E4 start at the top; the rest start at 0.
              elem <= elem + 3'd1;
              addr <= ((elem == 3'd2) || (elem == 3'd3)) ? A_LAST : '0;
            end
          end
          if (run_end) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (fail_cnt == '0);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_march_host_seq.sv
// Scoreboard bench for march_host_seq: expected accesses and mismatches are queued at START
// and popped as the DUT strobes CE / pulses fail_valid, against a stuck-at memory model.
module tb_march_host_seq;
  localparam int AW = 16, DW = 8, AMAX = 7, SC = 1, CC = 2, RL = 3, CW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  march_host_seq_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus();

  march_host_seq #(
    .ADDR_W(AW), .DATA_W(DW), .ADDR_MAX(AMAX), .SETUP_C(SC), .CE_C(CC), .RD_LAT(RL), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hif(bus)
  );

  typedef struct { logic wr; logic [AW-1:0] a; logic [DW-1:0] d; } acc_t;
  typedef struct { logic [AW-1:0] a; logic [2:0] el; } fl_t;

  acc_t acc_q[$];
  fl_t  fl_q[$];
  int   n_chk = 0, n_pass = 0;
  int   fault_cell = -1;
  bit   fault_all = 1'b0;
  logic [DW-1:0] mem [0:AMAX];
  int   acc_seen, fails_seen, busy_cyc, exp_busy;
  int   s_len, c_len, t_len;
  bit   skip_len = 1'b0, cur_wr = 1'b0;
  logic pce = 1'b0, pcsb = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Controller/memory model: cell(s) stuck-at-0 on read, writes land on the falling edge.
  assign bus.odata = (!bus.csb && !bus.oeb)
                   ? ((fault_all || (int'(bus.addr) == fault_cell)) ? '0 : mem[bus.addr[2:0]])
                   : 8'hA5;

  always @(negedge clk)
    if (bus.ce && !bus.csb && !bus.web) mem[bus.addr[2:0]] <= bus.idata;

  task automatic build_run();
    logic [DW-1:0] sh [0:AMAX];
    logic [DW-1:0] ex, wd, rv;
    acc_t e;
    fl_t  f;
    int   a, nwr, nrd;
    acc_q.delete();
    fl_q.delete();
    nwr = 0;
    nrd = 0;
    for (int el = 0; el < 6; el++) begin
      for (int k = 0; k <= AMAX; k++) begin
        a  = (el == 3 || el == 4) ? AMAX - k : k;
        ex = (el == 2 || el == 4) ? 8'hFF : 8'h00;
        wd = (el == 1 || el == 3) ? 8'hFF : 8'h00;
        if (el != 0) begin
          e.wr = 1'b0; e.a = a[AW-1:0]; e.d = ex;
          acc_q.push_back(e);
          nrd++;
          rv = (fault_all || a == fault_cell) ? 8'h00 : sh[a];
          if (rv !== ex) begin
            f.a = a[AW-1:0]; f.el = el[2:0];
            fl_q.push_back(f);
          end
        end
        if (el != 5) begin
          e.wr = 1'b1; e.a = a[AW-1:0]; e.d = wd;
          acc_q.push_back(e);
          nwr++;
          sh[a] = wd;
        end
      end
    end
    exp_busy = nwr * (SC + CC + 2) + nrd * (SC + CC + RL + 2);
  endtask

  // Pin monitor: pops the scoreboard at each CE rise and measures setup/strobe/tail lengths.
  initial begin : mon
    acc_t e;
    fl_t  f;
    forever begin
      @(negedge clk);
      if (rst) begin pce = 1'b0; pcsb = 1'b1; continue; end
      if (bus.busy) busy_cyc++;
      if (!bus.csb && pcsb) begin
        s_len = 0; c_len = 0; t_len = 0; skip_len = 1'b0; cur_wr = !bus.web;
      end
      if (!bus.csb) begin
        if (bus.ce) c_len++;
        else if (c_len == 0) s_len++;
        else t_len++;
      end
      if (bus.ce && !pce) begin
        acc_seen++;
        chk("acc_pending", acc_q.size() != 0, 1);
        if (acc_q.size() != 0) begin
          e = acc_q.pop_front();
          chk("acc_wr", !bus.web, e.wr);
          chk("acc_oeb", bus.oeb, e.wr);
          chk("acc_addr", bus.addr, e.a);
          if (e.wr) chk("acc_data", bus.idata, e.d);
        end
      end
      if (bus.csb && !pcsb && !skip_len) begin
        chk("setup_len", s_len, SC);
        chk("ce_len", c_len, CC);
        chk("tail_len", t_len, cur_wr ? 1 : 1 + RL);
      end
      if (bus.fail_valid) begin
        fails_seen++;
        chk("fail_pending", fl_q.size() != 0, 1);
        if (fl_q.size() != 0) begin
          f = fl_q.pop_front();
          chk("fail_addr", bus.fail_addr, f.a);
          chk("fail_elem", bus.fail_elem, f.el);
        end
        chk("fail_cnt_run", bus.fail_cnt, (fails_seen > 3) ? 3 : fails_seen);
      end
      pce  = bus.ce;
      pcsb = bus.csb;
    end
  end

  task automatic pulse_start();
    acc_seen = 0; fails_seen = 0; busy_cyc = 0;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic run_check(input string tag, input int restart_at);
    int exp_n, exp_acc;
    build_run();
    exp_n   = fl_q.size();
    exp_acc = acc_q.size();
    pulse_start();
    chk({tag, "_busy_on"}, bus.busy, 1);
    chk({tag, "_done_clr"}, bus.done, 0);
    chk({tag, "_cnt_clr"}, bus.fail_cnt, 0);
    for (int i = 0; i < 3000; i++) begin
      bus.start = (i == restart_at);
      if (bus.done) break;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_busy_off"}, bus.busy, 0);
    chk({tag, "_pass"}, bus.pass, exp_n == 0);
    chk({tag, "_fail_cnt"}, bus.fail_cnt, (exp_n > 3) ? 3 : exp_n);
    chk({tag, "_n_acc"}, acc_seen, exp_acc);
    chk({tag, "_acc_left"}, acc_q.size(), 0);
    chk({tag, "_fail_left"}, fl_q.size(), 0);
    chk({tag, "_busy_cyc"}, busy_cyc, exp_busy);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", bus.addr, 0);
    chk("rst_idata", bus.idata, 0);
    chk("rst_ce", bus.ce, 0);
    chk("rst_csb", bus.csb, 1);
    chk("rst_web", bus.web, 1);
    chk("rst_oeb", bus.oeb, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_pass", bus.pass, 0);
    chk("rst_fvalid", bus.fail_valid, 0);
    chk("rst_faddr", bus.fail_addr, 0);
    chk("rst_felem", bus.fail_elem, 0);
    chk("rst_fcnt", bus.fail_cnt, 0);
    rst = 1'b0;

    // START together with ABORT in IDLE is ignored
    @(posedge clk); #1 bus.start = 1'b1; bus.abort = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0; bus.abort = 1'b0;
    chk("sa_busy", bus.busy, 0);
    chk("sa_csb", bus.csb, 1);

    // fault-free run, with a stray START mid-run
    fault_cell = -1;
    run_check("t1", 100);
    chk("t1_busy_520", busy_cyc, 520);

    // cell 5 stuck-at-0
    fault_cell = 5;
    run_check("t2", -1);
    chk("t2_faddr", bus.fail_addr, 5);
    chk("t2_felem", bus.fail_elem, 4);
    chk("t2_fcnt", bus.fail_cnt, 2);
    chk("t2_pass", bus.pass, 0);

    // every cell stuck-at-0: counter saturates
    fault_all = 1'b1;
    fault_cell = -1;
    run_check("t5", -1);
    chk("t5_fcnt_sat", bus.fail_cnt, 3);
    fault_all = 1'b0;

    // abort mid-E3 (accesses 40..55), then restart clean
    fault_cell = 5;
    build_run();
    pulse_start();
    for (int i = 0; i < 2000; i++) begin
      if (acc_seen >= 46) break;
      @(posedge clk); #1;
    end
    chk("t3_reach_e3", acc_seen >= 46, 1);
    skip_len = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0;
    chk("t3_ce", bus.ce, 0);
    chk("t3_csb", bus.csb, 1);
    chk("t3_web", bus.web, 1);
    chk("t3_oeb", bus.oeb, 1);
    chk("t3_busy", bus.busy, 0);
    chk("t3_done", bus.done, 0);
    chk("t3_fcnt_kept", bus.fail_cnt, 1);
    chk("t3_felem_kept", bus.fail_elem, 2);
    chk("t3_faddr_kept", bus.fail_addr, 5);
    repeat (3) @(posedge clk);
    #1 chk("t3_idle_csb", bus.csb, 1);
    fault_cell = -1;
    run_check("t3r", -1);

    // asynchronous reset while CE is high
    build_run();
    pulse_start();
    for (int i = 0; i < 50; i++) begin
      if (bus.ce) break;
      @(posedge clk); #1;
    end
    chk("t4_in_strobe", bus.ce, 1);
    #1 rst = 1'b1;
    #1;
    chk("t4_ce", bus.ce, 0);
    chk("t4_csb", bus.csb, 1);
    chk("t4_web", bus.web, 1);
    chk("t4_oeb", bus.oeb, 1);
    chk("t4_busy", bus.busy, 0);
    chk("t4_addr", bus.addr, 0);
    chk("t4_idata", bus.idata, 0);
    chk("t4_fcnt", bus.fail_cnt, 0);
    @(posedge clk); #1 rst = 1'b0;
    acc_q.delete();
    fl_q.delete();
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
